counter_datapath: RTL and testbench
===================================

COUNTER_DATAPATH -- requirements
Module: counter_datapath

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; legal range 2..32.
REQ-002 Local parameter CW = ceil(log2(WIDTH+1)), the count width; 5 when WIDTH=16.
REQ-003 clk  input  1  clock; all registers update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_A  input  WIDTH  operand whose set bits are counted.
REQ-006 out_rst  input  1  load/clear strobe from the controller.
REQ-007 sft  input  1  shift strobe from the controller.
REQ-008 add  input  1  count-increment strobe from the controller.
REQ-009 done  input  1  completion strobe from the controller.
REQ-010 result_ack  input  1  consumer acknowledge of the held result.
REQ-011 z  output  1  high when the shift register A is all zeros.
REQ-012 a0  output  1  current LSB of A.
REQ-013 count  output  CW  live accumulator value.
REQ-014 result  output  CW  captured final count.
REQ-015 result_valid  output  1  result is held and not yet acknowledged.
REQ-016 overrun  output  1  sticky flag: a new result was captured over an unacknowledged one.

Function
REQ-017 The controller drives its strobes on the falling edge; this block samples them on the rising edge, so no extra synchronisation is added.
REQ-018 When out_rst=1: A loads in_A, count clears to 0, and any sft/add in the same cycle is ignored (out_rst has priority).
REQ-019 When sft=1 and out_rst=0: A shifts right one bit with 0 inserted at the MSB.
REQ-020 When add=1 and out_rst=0: count increments by 1 and saturates at WIDTH, never wrapping.
REQ-021 When sft and add are both 1: both operations take effect in the same edge, and add applies to the pre-shift A context.
REQ-022 With no strobe asserted, A and count hold their values.
REQ-023 z = (A == 0) and a0 = A[0], both purely combinational from the A register, with no added latency.
REQ-024 When done=1: result <= count in the same edge and result_valid <= 1, giving a result available one rising edge after done is sampled.
REQ-025 When result_ack=1 and done=0: result_valid <= 0 and result holds its value.
REQ-026 When done and result_ack are both 1: the new result is captured and result_valid stays 1.
REQ-027 When done=1 while result_valid=1 and result_ack=0: the result is overwritten and overrun <= 1.
REQ-028 overrun clears only on reset.
REQ-029 result_ack while result_valid=0 has no effect.
REQ-030 out_rst does not affect result, result_valid or overrun.

Reset
REQ-031 rst=0 immediately, without waiting for a clock edge, forces A=0, count=0, result=0, result_valid=0 and overrun=0, so z=1 and a0=0.
REQ-032 Reset asserted mid-operation abandons the operation; no partial result is captured.
REQ-033 After rst deasserts, the first out_rst reloads A.

Verification
REQ-034 WIDTH=16, in_A=16'h00B5 (out_rst), then sequence the controller to completion -> result=5, result_valid=1, overrun=0.
REQ-035 in_A=16'h0000 -> z=1 after load; one shift then done -> result=0.
REQ-036 in_A=16'hFFFF, with add and sft every iteration -> count reaches 16, then result=16; further add strobes keep count at 16 (saturation).
REQ-037 Two done strobes without result_ack -> overrun=1 and result equals the second count; result_ack then clears result_valid while overrun stays 1.
REQ-038 out_rst, sft and add in the same cycle with in_A=16'h0003 -> A=16'h0003 and count=0.
REQ-039 rst pulsed low between clock edges during a shift phase -> all outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/counter_datapath.sv
// Datapath of a set-bit counter: a right-shifting operand register, a saturating
// accumulator, and a result holding register with valid/acknowledge and overrun.
module counter_datapath #(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_A,
  input  logic             out_rst,
  input  logic             sft,
  input  logic             add,
  input  logic             done,
  input  logic             result_ack,
  output logic             z,
  output logic             a0,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    result,
  output logic             result_valid,
  output logic             overrun
);

  localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] a_reg;
  logic [CW-1:0]    count_reg;

  // The count can never exceed the number of operand bits, so it pins at WIDTH.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v >= COUNT_MAX) return COUNT_MAX;
    return v + 1'b1;
  endfunction

  // Controller strobes arrive on the falling edge and are stable here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg     <= '0;
      count_reg <= '0;
    end else if (out_rst) begin
      a_reg     <= in_A;
      count_reg <= '0;
    end else begin
      if (sft) a_reg <= {1'b0, a_reg[WIDTH-1:1]};
      if (add) count_reg <= sat_inc(count_reg);
    end
  end

  // Result capture is independent of out_rst so a reload cannot disturb a held result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (done) begin
      result       <= count_reg;
      result_valid <= 1'b1;
      if (result_valid && !result_ack) overrun <= 1'b1;
    end else if (result_ack) begin
      result_valid <= 1'b0;
    end
  end

  assign z     = (a_reg == '0);
  assign a0    = a_reg[0];
  assign count = count_reg;

endmodule

// File: tb/tb_counter_datapath.sv
// Directed bench for counter_datapath: popcount runs, saturation, overrun,
// strobe priority and asynchronous reset.
module tb_counter_datapath;

  localparam int WIDTH = 16;
  localparam int CW    = 5;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_A;
  logic             out_rst, sft, add, done, result_ack;
  logic             z, a0, result_valid, overrun;
  logic [CW-1:0]    count, result;

  int n_tests = 0;
  int n_fail  = 0;

  counter_datapath #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_A(in_A),
    .out_rst(out_rst), .sft(sft), .add(add), .done(done), .result_ack(result_ack),
    .z(z), .a0(a0), .count(count), .result(result),
    .result_valid(result_valid), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One controller cycle: assert the given strobes for exactly one rising edge.
  task automatic strobe(input logic r, input logic s, input logic a,
                        input logic d, input logic k);
    out_rst = r; sft = s; add = a; done = d; result_ack = k;
    tick();
    out_rst = 0; sft = 0; add = 0; done = 0; result_ack = 0;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    in_A = v;
    strobe(1, 0, 0, 0, 0);
  endtask

  // Popcount controller: add on a set LSB, shift every iteration, stop on zero.
  task automatic run_popcount();
    for (int i = 0; i < 40 && !z; i++) strobe(0, 1, a0, 0, 0);
    check("run_reaches_zero", z, 1);
  endtask

  initial begin
    in_A = '0; out_rst = 0; sft = 0; add = 0; done = 0; result_ack = 0;
    rst = 1;
    #2 rst = 0;
    #1;
    check("rst_z", z, 1);
    check("rst_a0", a0, 0);
    check("rst_count", count, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1;

    // 0x00B5 has five set bits
    load(16'h00B5);
    check("b5_load_z", z, 0);
    check("b5_load_a0", a0, 1);
    check("b5_load_count", count, 0);
    run_popcount();
    check("b5_count", count, 5);
    check("b5_valid_before_done", result_valid, 0);
    strobe(0, 0, 0, 1, 0);
    check("b5_result", result, 5);
    check("b5_valid", result_valid, 1);
    check("b5_overrun", overrun, 0);
    strobe(0, 0, 0, 0, 1);
    check("b5_ack_valid", result_valid, 0);
    check("b5_ack_result_held", result, 5);
    strobe(0, 0, 0, 0, 1);
    check("idle_ack_valid", result_valid, 0);
    check("idle_ack_overrun", overrun, 0);

    // zero operand
    load(16'h0000);
    check("zero_load_z", z, 1);
    strobe(0, 1, 0, 0, 0);
    strobe(0, 0, 0, 1, 0);
    check("zero_result", result, 0);
    check("zero_valid", result_valid, 1);
    strobe(0, 0, 0, 0, 1);

    // all ones with add+sft every iteration, then saturation
    load(16'hFFFF);
    for (int i = 0; i < 16; i++) strobe(0, 1, 1, 0, 0);
    check("ffff_count", count, 16);
    check("ffff_z", z, 1);
    strobe(0, 0, 0, 1, 0);
    check("ffff_result", result, 16);
    for (int i = 0; i < 3; i++) strobe(0, 0, 1, 0, 0);
    check("sat_count", count, 16);
    strobe(0, 0, 0, 1, 1);
    check("done_ack_result", result, 16);
    check("done_ack_valid", result_valid, 1);
    check("done_ack_no_overrun", overrun, 0);
    strobe(0, 0, 0, 0, 1);
    check("ffff_ack_valid", result_valid, 0);

    // overrun: two done strobes without acknowledge
    load(16'h0003);
    strobe(0, 0, 1, 0, 0);
    strobe(0, 0, 0, 1, 0);
    check("ov_first_result", result, 1);
    check("ov_first_flag", overrun, 0);
    strobe(0, 0, 1, 0, 0);
    strobe(0, 0, 0, 1, 0);
    check("ov_second_result", result, 2);
    check("ov_flag", overrun, 1);
    check("ov_valid", result_valid, 1);
    strobe(0, 0, 0, 0, 1);
    check("ov_ack_valid", result_valid, 0);
    check("ov_sticky", overrun, 1);

    // out_rst wins over sft/add and leaves the result side alone
    strobe(0, 0, 1, 0, 0);
    in_A = 16'h0003;
    strobe(1, 1, 1, 0, 0);
    check("prio_count", count, 0);
    check("prio_a0", a0, 1);
    check("prio_z", z, 0);
    check("prio_result_kept", result, 2);
    check("prio_overrun_kept", overrun, 1);
    strobe(0, 1, 0, 0, 0);
    check("prio_shift1_a0", a0, 1);
    check("prio_shift1_z", z, 0);
    strobe(0, 1, 0, 0, 0);
    check("prio_shift2_z", z, 1);

    // asynchronous reset in the middle of a shift phase
    load(16'h00B5);
    strobe(0, 1, 1, 0, 0);
    strobe(0, 1, 0, 0, 0);
    check("mid_count", count, 1);
    sft = 1;
    #3 rst = 0;
    #1;
    check("async_z", z, 1);
    check("async_a0", a0, 0);
    check("async_count", count, 0);
    check("async_result", result, 0);
    check("async_valid", result_valid, 0);
    check("async_overrun", overrun, 0);
    sft = 0;
    #1 rst = 1;
    tick();
    check("post_rst_z", z, 1);
    load(16'h0001);
    check("reload_a0", a0, 1);
    check("reload_z", z, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
